health_state_ctrl: RTL

- Sequencing controller that produces the 4-bit health state consumed by the state-to-BCD display mapper.
- Classifies a stream of sensor samples into the four health zones.
- Applies persistence filtering and hysteresis, latches EMERGENCY until operator acknowledge, and forces a FAULT state when samples stop arriving.
- Sits between the sensor sampling logic and the 7-segment display path.

---
 rtl/health_state_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/health_state_ctrl.sv
// Health-state sequencer: classifies sensor samples into zones, applies persistence, hysteresis,
// the EMERGENCY latch and the sample timeout. Define HEALTH_BLINK_EN to enable the alarm blink counter.
module health_state_ctrl #(
  parameter int DATA_W    = 8,
  parameter int TH_BORDER = 100,
  parameter int TH_ATTN   = 120,
  parameter int TH_EMERG  = 140,
  parameter int HYST      = 4,
  parameter int PERSIST   = 3,
  parameter int TIMEOUT   = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              ack,
  output logic [3:0]        state,
  output logic              alarm,
  output logic              changed,
  output logic              blink
);

  localparam logic [3:0] ST_EMERG = 4'd3;
  localparam logic [3:0] ST_FAULT = 4'hF;

  localparam int CNT_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  PERSIST_C  = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [TMO_W-1:0]  TIMEOUT_C  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]  TIMEOUT_M1 = TMO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TH_B_C     = DATA_W'(TH_BORDER);
  localparam logic [DATA_W-1:0] TH_A_C     = DATA_W'(TH_ATTN);
  localparam logic [DATA_W-1:0] TH_E_C     = DATA_W'(TH_EMERG);
  localparam logic [DATA_W:0]   HYST_C     = (DATA_W + 1)'(HYST);

  if (PERSIST < 1) begin : g_bad_persist
    $error("PERSIST must be at least 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  function automatic logic [1:0] zone_of(input logic [DATA_W-1:0] s);
    if (s >= TH_E_C)      return 2'd3;
    else if (s >= TH_A_C) return 2'd2;
    else if (s >= TH_B_C) return 2'd1;
    else                  return 2'd0;
  endfunction

  function automatic logic [DATA_W-1:0] sat_add_hyst(input logic [DATA_W-1:0] s);
    logic [DATA_W:0] sum;
    sum = {1'b0, s} + HYST_C;
    return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction

  logic [3:0]       state_q, state_d;
  logic             alarm_q, alarm_d;
  logic             changed_q, changed_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       last_e_q, last_e_d;

  logic [1:0]       z, z_hyst, cur, e, cand_n;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    z      = zone_of(sample);
    z_hyst = zone_of(sat_add_hyst(sample));
    cur    = state_q[1:0];
    // Falling zones must clear the threshold by HYST, and never rise above the current state.
    if (z >= cur)          e = z;
    else if (z_hyst > cur) e = cur;
    else                   e = z_hyst;

    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    last_e_d = last_e_q;
    cand_n   = cand_q;
    cnt_n    = cnt_q;

    if (sample_valid)            tmo_d = '0;
    else if (tmo_q != TIMEOUT_C) tmo_d = tmo_q + 1'b1;
    else                         tmo_d = tmo_q;

    if (state_q == ST_FAULT) begin
      if (sample_valid) begin
        state_d  = {2'b00, z};
        cand_d   = z;
        cnt_d    = '0;
        last_e_d = z;
      end
    end else begin
      if (sample_valid) begin
        last_e_d = e;
        if (e == cand_q) begin
          cand_n = cand_q;
          cnt_n  = (cnt_q >= PERSIST_C) ? PERSIST_C : cnt_q + 1'b1;
        end else begin
          cand_n = e;
          cnt_n  = CNT_ONE;
        end
        cand_d = cand_n;
        cnt_d  = cnt_n;
        if ((cnt_n == PERSIST_C) && (cand_n != cur) && (state_q != ST_EMERG)) begin
          state_d = {2'b00, cand_n};
          cnt_d   = '0;
        end
      end
      // last_e_d already reflects a sample arriving in the same cycle as ack.
      if (ack && (state_q == ST_EMERG) && (last_e_d != 2'd3)) begin
        state_d = {2'b00, last_e_d};
        cnt_d   = '0;
      end
      if (!sample_valid && (tmo_q == TIMEOUT_M1)) begin
        state_d = ST_FAULT;
      end
    end

    changed_d = (state_d != state_q);
    alarm_d   = (state_d == ST_EMERG) || (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      alarm_q   <= 1'b0;
      changed_q <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      last_e_q  <= '0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      changed_q <= changed_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      last_e_q  <= last_e_d;
    end
  end

  assign state   = state_q;
  assign alarm   = alarm_q;
  assign changed = changed_q;

`ifdef HEALTH_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (!alarm_q) begin
      blk_cnt_d = '0;
      blink_d   = 1'b0;
    end else if (blk_cnt_q == BLINK_LAST) begin
      blk_cnt_d = '0;
      blink_d   = ~blink_q;
    end else begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule
